// File: rtl/load_hist_pkg.sv
// Shared debounce state encoding and default sizing for the load history register.
package load_hist_pkg;

    localparam int unsigned DEF_WIDTH      = 5;
    localparam int unsigned DEF_DEPTH      = 4;
    localparam int unsigned DEF_DEB_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2,
        DEB_REL   = 2'd3
    } deb_state_e;

endpackage

// File: rtl/btn_pulse_gen.sv
// Synchronises and debounces a raw push-button; emits a registered one-clock pulse per stable press.
// Pulse appears DEB_CYCLES+2 edges after the first edge sampling the press; no backpressure.
module btn_pulse_gen
    import load_hist_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic bot_raw,
    output logic bot_pulse
);

    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    if (DEB_CYCLES < 1) begin : g_bad_deb
        $error("btn_pulse_gen: DEB_CYCLES must be at least 1");
    end

    logic          sync1_q, sync1_d;
    logic          bsync_q, bsync_d;
    logic [1:0]    prime_q, prime_d;
    logic          armed_q, armed_d;
    deb_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          pulse_q, pulse_d;

    // The synchronizer resets to 0, so its first output after reset is not a real
    // sample. prime_q marks when bsync is trustworthy; armed_q then requires a real
    // released level before a press is accepted, so a button held through reset
    // never fires.
    always_comb begin
        sync1_d = bot_raw;
        bsync_d = sync1_q;
        prime_d = {prime_q[0], 1'b1};
        armed_d = armed_q | (prime_q[1] & ~bsync_q);
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bsync_q && armed_q) begin
                    state_d = DEB_PRESS;
                    cnt_d   = '0;
                end
            end
            DEB_PRESS: begin
                if (!bsync_q) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!bsync_q) begin
                    state_d = DEB_REL;
                    cnt_d   = '0;
                end
            end
            DEB_REL: begin
                if (bsync_q) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            bsync_q <= 1'b0;
            prime_q <= 2'b00;
            armed_q <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            bsync_q <= bsync_d;
            prime_q <= prime_d;
            armed_q <= armed_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign bot_pulse = pulse_q;

endmodule

// File: rtl/load_hist_reg.sv
// Captures load_data into a DEPTH-entry circular history on each debounced button press.
// Capture lands one edge after bot_pulse; rd_data is combinational; no backpressure, oldest entry overwritten when full.
module load_hist_reg
    import load_hist_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       bot_raw,
    input  logic [WIDTH-1:0]           load_data,
    input  logic                       clr,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [WIDTH-1:0]           store_state,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       bot_pulse
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("load_hist_reg: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] hist_q [DEPTH];
    logic [WIDTH-1:0] hist_d [DEPTH];
    logic [IW-1:0]    head_q, head_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] store_state_q, store_state_d;
    logic             full_w;
    logic [IW-1:0]    rd_slot;

    btn_pulse_gen #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_btn_pulse_gen (
        .clk       (clk),
        .rst       (rst),
        .bot_raw   (bot_raw),
        .bot_pulse (bot_pulse)
    );

    assign full_w = (count_q == CW'(DEPTH));

    // head_q always points at the slot the next capture will overwrite; with a
    // power-of-two DEPTH the pointer arithmetic wraps for free.
    always_comb begin
        hist_d        = hist_q;
        head_d        = head_q;
        count_d       = count_q;
        store_state_d = store_state_q;

        if (clr) begin
            head_d        = '0;
            count_d       = '0;
            store_state_d = '0;
        end else if (bot_pulse) begin
            hist_d[head_q] = load_data;
            head_d         = head_q + 1'b1;
            store_state_d  = load_data;
            if (!full_w) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                hist_q[i] <= '0;
            end
            head_q        <= '0;
            count_q       <= '0;
            store_state_q <= '0;
        end else begin
            hist_q        <= hist_d;
            head_q        <= head_d;
            count_q       <= count_d;
            store_state_q <= store_state_d;
        end
    end

    // Entries beyond count may hold stale data after a clear, so they read as 0.
    always_comb begin
        rd_slot = head_q - 1'b1 - rd_idx;
        rd_data = '0;
        if (CW'(rd_idx) < count_q) begin
            rd_data = hist_q[rd_slot];
        end
    end

    assign store_state = store_state_q;
    assign count       = count_q;
    assign full        = full_w;

endmodule

// File: tb/tb_load_hist_reg.sv
// Directed bench for load_hist_reg with a capture scoreboard and a small history model.
module tb_load_hist_reg;

    localparam int WIDTH = 5;
    localparam int DEPTH = 4;
    localparam int DEB   = 4;

    logic             clk;
    logic             rst;
    logic             bot_raw;
    logic [WIDTH-1:0] load_data;
    logic             clr;
    logic [1:0]       rd_idx;
    logic [WIDTH-1:0] store_state;
    logic [WIDTH-1:0] rd_data;
    logic [2:0]       count;
    logic             full;
    logic             bot_pulse;

    load_hist_reg #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bot_raw     (bot_raw),
        .load_data   (load_data),
        .clr         (clr),
        .rd_idx      (rd_idx),
        .store_state (store_state),
        .rd_data     (rd_data),
        .count       (count),
        .full        (full),
        .bot_pulse   (bot_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] hist_m [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "/count"}, 32'(count), 32'(hist_m.size()));
        chk({tag, "/full"}, 32'(full), 32'(hist_m.size() == DEPTH));
        chk({tag, "/store"}, 32'(store_state),
            (hist_m.size() > 0) ? 32'(hist_m[0]) : 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            rd_idx = 2'(i);
            #1;
            chk($sformatf("%s/rd%0d", tag, i), 32'(rd_data),
                (i < hist_m.size()) ? 32'(hist_m[i]) : 32'd0);
        end
        rd_idx = 2'd0;
    endtask

    // Bit k of pat is the bot_raw level for step k; each step ends one negedge later.
    task automatic run_pat(input logic [63:0] pat, input int len, input bit clr_mode,
                           output int npulse, output int first_at);
        bit               prev;
        logic [WIDTH-1:0] v;
        prev     = 1'b0;
        npulse   = 0;
        first_at = -1;
        for (int k = 0; k < len; k++) begin
            bot_raw = pat[k];
            @(negedge clk);
            if (prev) begin
                if (clr_mode) begin
                    clr = 1'b0;
                    chk("clr_win/store", 32'(store_state), 32'd0);
                    chk("clr_win/count", 32'(count), 32'd0);
                    hist_m.delete();
                end else if (exp_q.size() > 0) begin
                    v = exp_q.pop_front();
                    chk("capture/store", 32'(store_state), 32'(v));
                    hist_m.push_front(v);
                    if (hist_m.size() > DEPTH) begin
                        void'(hist_m.pop_back());
                    end
                end
            end
            prev = bot_pulse;
            if (bot_pulse) begin
                npulse++;
                if (first_at < 0) first_at = k;
                if (clr_mode) clr = 1'b1;
            end
        end
    endtask

    initial begin
        int np;
        int fa;

        rst       = 1'b0;
        bot_raw   = 1'b0;
        clr       = 1'b0;
        load_data = '0;
        rd_idx    = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst/pulse", 32'(bot_pulse), 32'd0);
        check_state("rst");
        rst = 1'b1;
        @(negedge clk);

        // Bouncing press 1,1,0,1,1,0 never stays stable long enough
        run_pat(64'h1B, 16, 1'b0, np, fa);
        chk("bounce/npulse", 32'(np), 32'd0);
        check_state("bounce");

        load_data = 5'h13;
        exp_q.push_back(5'h13);
        run_pat(64'hFFF, 22, 1'b0, np, fa);
        chk("clean/npulse", 32'(np), 32'd1);
        chk("clean/latency", 32'(fa), 32'(DEB + 2));
        check_state("clean");

        // Held press with a short release glitch: still one pulse
        load_data = 5'h0A;
        exp_q.push_back(5'h0A);
        run_pat(64'h73FF, 27, 1'b0, np, fa);
        chk("glitch/npulse", 32'(np), 32'd1);
        chk("glitch/latency", 32'(fa), 32'(DEB + 2));
        check_state("glitch");

        for (int v = 1; v <= 5; v++) begin
            load_data = 5'(v);
            exp_q.push_back(5'(v));
            run_pat(64'hFFF, 22, 1'b0, np, fa);
            chk($sformatf("wrap%0d/npulse", v), 32'(np), 32'd1);
        end
        check_state("wrap");

        // Reset in the middle of a debounce while the button stays down
        bot_raw = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        hist_m.delete();
        exp_q.delete();
        chk("midrst/pulse", 32'(bot_pulse), 32'd0);
        check_state("midrst");
        @(negedge clk);
        rst = 1'b1;
        run_pat(64'hFFFFF, 20, 1'b0, np, fa);
        chk("stuck/npulse", 32'(np), 32'd0);
        check_state("stuck");

        load_data = 5'h07;
        exp_q.push_back(5'h07);
        run_pat(64'h3FFC00, 32, 1'b0, np, fa);
        chk("repress/npulse", 32'(np), 32'd1);
        chk("repress/latency", 32'(fa), 32'(10 + DEB + 2));
        check_state("repress");

        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        hist_m.delete();
        check_state("clr");

        load_data = 5'h08;
        exp_q.push_back(5'h08);
        run_pat(64'hFFF, 22, 1'b0, np, fa);
        load_data = 5'h09;
        exp_q.push_back(5'h09);
        run_pat(64'hFFF, 22, 1'b0, np, fa);
        check_state("two");

        // clr coincides with the pulse: capture must be dropped
        load_data = 5'h1F;
        run_pat(64'hFFF, 22, 1'b1, np, fa);
        chk("collide/npulse", 32'(np), 32'd1);
        check_state("collide");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
